// File: rtl/tanimoto_accel.sv
// Streaming Tanimoto screening engine: latches SHR_DEPTH reference fingerprints, then compares
// each later fingerprint against all of them. Optional match counter: TANIMOTO_MATCH_CNT_EN.
module tanimoto_accel #(
  parameter  int BUS_WIDTH     = 512,
  parameter  int VECTOR_WIDTH  = 920,
  parameter  int SUB_VECTOR_NO = 2,
  parameter  int GRANULE_WIDTH = 6,
  parameter  int SHR_DEPTH     = 32,
  parameter  int VEC_ID_WIDTH  = $clog2(VECTOR_WIDTH),
  parameter  int OUT_DEPTH     = 16,
  localparam int CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [BUS_WIDTH-1:0]      i_Vector,
  input  logic                      i_Valid,
  output logic                      o_Read,
  input  logic [CNT_WIDTH-1:0]      i_BRAM_Addr,
  input  logic [CNT_WIDTH:0]        i_BRAM_Din,
  input  logic                      i_BRAM_En,
  input  logic                      i_BRAM_WrEn,
`ifdef TANIMOTO_MATCH_CNT_EN
  output logic [31:0]               o_Match_Count,
`endif
  output logic                      o_IDPair_Ready,
  output logic [2*VEC_ID_WIDTH-1:0] o_IDPair_Out,
  input  logic                      i_IDPair_Read
);
  localparam int SW    = CNT_WIDTH + 1;
  localparam int SUBW  = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int REFW  = (SHR_DEPTH > 1) ? $clog2(SHR_DEPTH) : 1;
  localparam int QW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int PW    = 2 * VEC_ID_WIDTH;
  localparam int ASMW  = SUB_VECTOR_NO * BUS_WIDTH;
  localparam int NGRAN = (VECTOR_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;

  typedef enum logic [1:0] {LOAD_REF, GATHER, POPCNT, COMPARE} state_t;

  function automatic logic [SW-1:0] popcnt(input logic [VECTOR_WIDTH-1:0] v);
    logic [NGRAN*GRANULE_WIDTH-1:0] vp;
    logic [SW-1:0] acc;
    logic [SW-1:0] gsum;
    vp = '0;
    vp[VECTOR_WIDTH-1:0] = v;
    acc = '0;
    for (int g = 0; g < NGRAN; g++) begin
      gsum = '0;
      for (int b = 0; b < GRANULE_WIDTH; b++) gsum = gsum + SW'(vp[g*GRANULE_WIDTH+b]);
      acc = acc + gsum;
    end
    return acc;
  endfunction

  state_t                    state_q, state_d;
  logic                      rd_q;
  logic [SUBW-1:0]           sub_q;
  logic [ASMW-1:0]           vec_q, asm_vec;
  logic [VECTOR_WIDTH-1:0]   full_vec, pc_src;
  logic [SW-1:0]             pc;
  logic [VEC_ID_WIDTH-1:0]   id_q;
  logic [REFW-1:0]           ref_cnt_q, iss_q;
  logic [VECTOR_WIDTH-1:0]   ref_vec_q [SHR_DEPTH];
  logic [SW-1:0]             ref_pc_q  [SHR_DEPTH];
  logic [VEC_ID_WIDTH-1:0]   ref_id_q  [SHR_DEPTH];
  logic [SHR_DEPTH-1:0]      ref_vld_q;
  logic [VECTOR_WIDTH-1:0]   cand_q;
  logic [SW-1:0]             cand_pc_q;
  logic [VEC_ID_WIDTH-1:0]   cand_id_q;
  logic [SW-1:0]             tbl [2**CNT_WIDTH];
  logic                      s1_vld_q, s2_vld_q;
  logic [SW-1:0]             s1_isect_q, s1_sum_q, s2_isect_q, s2_thr_q;
  logic [PW-1:0]             s1_pair_q, s2_pair_q;
  logic [PW-1:0]             q_mem [OUT_DEPTH];
  logic [QW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [QW:0]               q_cnt_q;
  logic [QW+1:0]             occ_total;
  logic                      consume, last_word, fp_done, last_ref, last_iss, can_issue, push, pop;

  always_comb begin
    consume   = rd_q && i_Valid;
    last_word = (sub_q == SUBW'(SUB_VECTOR_NO - 1));
    fp_done   = consume && last_word;
    last_ref  = (ref_cnt_q == REFW'(SHR_DEPTH - 1));
    last_iss  = (iss_q == REFW'(SHR_DEPTH - 1));
    // Pairs already issued but not yet queued count against the queue so a push never overflows.
    occ_total = (QW+2)'(q_cnt_q) + (QW+2)'(s1_vld_q) + (QW+2)'(s2_vld_q);
    can_issue = (state_q == COMPARE) && (occ_total < (QW+2)'(OUT_DEPTH));
    push      = s2_vld_q && (s2_isect_q >= s2_thr_q);
    pop       = i_IDPair_Read && (q_cnt_q != '0);
    asm_vec   = vec_q;
    asm_vec[(SUB_VECTOR_NO-1)*BUS_WIDTH +: BUS_WIDTH] = i_Vector;
    full_vec  = asm_vec[VECTOR_WIDTH-1:0];
    pc_src    = (state_q == POPCNT) ? cand_q : full_vec;
    pc        = popcnt(pc_src);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_REF: if (fp_done && last_ref) state_d = GATHER;
      GATHER:   if (fp_done) state_d = POPCNT;
      POPCNT:   state_d = COMPARE;
      COMPARE:  if (can_issue && last_iss) state_d = GATHER;
      default:  state_d = LOAD_REF;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LOAD_REF;
      rd_q      <= 1'b0;
      sub_q     <= '0;
      id_q      <= '0;
      ref_cnt_q <= '0;
      ref_vld_q <= '0;
      iss_q     <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= (state_d == LOAD_REF) || (state_d == GATHER);
      if (consume) sub_q <= last_word ? '0 : sub_q + 1'b1;
      if (fp_done) id_q <= id_q + 1'b1;
      if (fp_done && state_q == LOAD_REF) begin
        ref_cnt_q            <= last_ref ? '0 : ref_cnt_q + 1'b1;
        ref_vld_q[ref_cnt_q] <= 1'b1;
      end
      if (can_issue) iss_q <= last_iss ? '0 : iss_q + 1'b1;
      s1_vld_q <= can_issue && ref_vld_q[iss_q];
      s2_vld_q <= s1_vld_q;
      if (push) wr_ptr_q <= (wr_ptr_q == QW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == QW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      q_cnt_q <= q_cnt_q + 1'b1;
      else if (!push && pop) q_cnt_q <= q_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (consume && !last_word) vec_q[sub_q*BUS_WIDTH +: BUS_WIDTH] <= i_Vector;
    if (fp_done && state_q == LOAD_REF) begin
      ref_vec_q[ref_cnt_q] <= full_vec;
      ref_pc_q[ref_cnt_q]  <= pc;
      ref_id_q[ref_cnt_q]  <= id_q;
    end
    if (fp_done && state_q == GATHER) begin
      cand_q    <= full_vec;
      cand_id_q <= id_q;
    end
    if (state_q == POPCNT) cand_pc_q <= pc;
    if (can_issue) begin
      s1_isect_q <= popcnt(ref_vec_q[iss_q] & cand_q);
      s1_sum_q   <= ref_pc_q[iss_q] + cand_pc_q;
      s1_pair_q  <= {ref_id_q[iss_q], cand_id_q};
    end
    s2_isect_q <= s1_isect_q;
    s2_thr_q   <= tbl[s1_sum_q[SW-1:1]];
    s2_pair_q  <= s1_pair_q;
    if (push) q_mem[wr_ptr_q] <= s2_pair_q;
    if (i_BRAM_En && i_BRAM_WrEn) tbl[i_BRAM_Addr] <= i_BRAM_Din;
  end

`ifdef TANIMOTO_MATCH_CNT_EN
  logic [31:0] match_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     match_cnt_q <= '0;
    else if (push) match_cnt_q <= match_cnt_q + 32'd1;
  end
  assign o_Match_Count = match_cnt_q;
`endif

  assign o_Read         = rd_q;
  assign o_IDPair_Ready = (q_cnt_q != '0);
  assign o_IDPair_Out   = (q_cnt_q != '0) ? q_mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_tanimoto_accel.sv
// Directed bench for tanimoto_accel: scenario table plus hand-written reset/backpressure sequences.
module tb_tanimoto_accel;
  logic          clk = 1'b0;
  logic          rstn;
  logic [511:0]  i_Vector;
  logic          i_Valid;
  logic          o_Read;
  logic [9:0]    i_BRAM_Addr;
  logic [10:0]   i_BRAM_Din;
  logic          i_BRAM_En, i_BRAM_WrEn;
  logic          o_IDPair_Ready;
  logic [19:0]   o_IDPair_Out;
  logic          i_IDPair_Read;

  tanimoto_accel dut (
    .clk(clk), .rstn(rstn), .i_Vector(i_Vector), .i_Valid(i_Valid), .o_Read(o_Read),
    .i_BRAM_Addr(i_BRAM_Addr), .i_BRAM_Din(i_BRAM_Din), .i_BRAM_En(i_BRAM_En),
    .i_BRAM_WrEn(i_BRAM_WrEn), .o_IDPair_Ready(o_IDPair_Ready), .o_IDPair_Out(o_IDPair_Out),
    .i_IDPair_Read(i_IDPair_Read)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tbl_mode;   // 0 fill constant, 1 fill identity, 2 single write at 920
    int tbl_val;
    int fp_mode;    // 0 random, 1 all ones, 2 ladder
    int n_fp;
    bit thr;
    int r_lo;
    int r_hi;
  } vec_t;

  int           n_vec = 0;
  int           n_err = 0;
  logic [511:0] wq[$];
  logic [19:0]  got[$];
  bit           throttle = 1'b0;
  int           low_run = 0;
  int           max_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1023:0] mk_fp(input int mode, input int idx);
    logic [1023:0] v;
    v = '0;
    if (mode == 0) begin
      for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
    end else if (mode == 1) begin
      v = '1;
    end else begin
      v[1023:920] = '1;
      for (int b = 0; b < 920; b++)
        if ((idx < 32 && b <= idx) || (idx >= 32 && b < 16)) v[919-b] = 1'b1;
    end
    return v;
  endfunction

  task automatic push_fp(input logic [1023:0] v);
    wq.push_back(v[511:0]);
    wq.push_back(v[1023:512]);
  endtask

  task automatic tbl_fill(input int mode, input int val);
    for (int a = 0; a < 1024; a++) begin
      i_BRAM_En = 1'b1; i_BRAM_WrEn = 1'b1;
      i_BRAM_Addr = 10'(a);
      i_BRAM_Din = (mode == 1) ? 11'(a) : 11'(val);
      tick(1);
    end
    i_BRAM_En = 1'b0; i_BRAM_WrEn = 1'b0;
  endtask

  task automatic tbl_one(input int addr, input int val);
    i_BRAM_En = 1'b1; i_BRAM_WrEn = 1'b1;
    i_BRAM_Addr = 10'(addr); i_BRAM_Din = 11'(val);
    tick(1);
    i_BRAM_En = 1'b0; i_BRAM_WrEn = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    wq.delete();
    tick(3);
    rstn = 1'b1;
    got.delete();
    max_low = 0;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (wq.size() != 0 && t < 20000) begin
      tick(1);
      t++;
    end
    check({nm, " drain"}, 32'(t < 20000), 32'd1);
  endtask

  // Upstream FWFT FIFO model
  initial begin
    bit fire;
    bit gate;
    gate = 1'b0;
    i_Valid = 1'b0;
    i_Vector = '0;
    forever begin
      @(negedge clk);
      fire = o_Read && i_Valid;
      @(posedge clk);
      #1;
      if (fire && wq.size() > 0) void'(wq.pop_front());
      gate = throttle ? ~gate : 1'b1;
      i_Valid = gate && (wq.size() > 0);
      i_Vector = (wq.size() > 0) ? wq[0] : '0;
    end
  end

  // Output collector and o_Read low-run tracker
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) low_run = 0;
      else begin
        if (o_IDPair_Ready && i_IDPair_Read) got.push_back(o_IDPair_Out);
        if (!o_Read) begin
          low_run++;
          if (low_run > max_low) max_low = low_run;
        end else low_run = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    logic [19:0] exp[$];
    string nm;
    int t;

    vt[0] = '{tbl_mode: 0, tbl_val: 0,    fp_mode: 0, n_fp: 33, thr: 1'b0, r_lo: 0,  r_hi: 31};
    vt[1] = '{tbl_mode: 0, tbl_val: 2047, fp_mode: 0, n_fp: 40, thr: 1'b0, r_lo: 1,  r_hi: 0};
    vt[2] = '{tbl_mode: 2, tbl_val: 920,  fp_mode: 1, n_fp: 34, thr: 1'b0, r_lo: 0,  r_hi: 31};
    vt[3] = '{tbl_mode: 2, tbl_val: 921,  fp_mode: 1, n_fp: 34, thr: 1'b0, r_lo: 1,  r_hi: 0};
    vt[4] = '{tbl_mode: 0, tbl_val: 0,    fp_mode: 0, n_fp: 33, thr: 1'b1, r_lo: 0,  r_hi: 31};
    vt[5] = '{tbl_mode: 1, tbl_val: 0,    fp_mode: 2, n_fp: 33, thr: 1'b0, r_lo: 14, r_hi: 16};

    rstn = 1'b0;
    i_BRAM_Addr = '0; i_BRAM_Din = '0; i_BRAM_En = 1'b0; i_BRAM_WrEn = 1'b0;
    i_IDPair_Read = 1'b1;
    tick(2);
    check("rst o_Read", 32'(o_Read), 32'd0);
    check("rst ready", 32'(o_IDPair_Ready), 32'd0);
    check("rst out", 32'(o_IDPair_Out), 32'd0);
    rstn = 1'b1;
    check("o_Read before first clk", 32'(o_Read), 32'd0);
    tick(1);
    check("o_Read after first clk", 32'(o_Read), 32'd1);

    for (int s = 0; s < 6; s++) begin
      nm = $sformatf("scn%0d", s);
      do_reset();
      if (vt[s].tbl_mode == 2) tbl_one(920, vt[s].tbl_val);
      else tbl_fill(vt[s].tbl_mode, vt[s].tbl_val);
      throttle = vt[s].thr;
      i_IDPair_Read = 1'b1;
      for (int f = 0; f < vt[s].n_fp; f++) push_fp(mk_fp(vt[s].fp_mode, f));
      wait_drain(nm);
      tick(60);
      throttle = 1'b0;
      exp.delete();
      for (int c = 0; c < vt[s].n_fp - 32; c++)
        for (int r = vt[s].r_lo; r <= vt[s].r_hi; r++) exp.push_back({10'(r), 10'(32 + c)});
      check({nm, " count"}, 32'(got.size()), 32'(exp.size()));
      for (int k = 0; k < got.size() && k < exp.size(); k++)
        check($sformatf("%s pair%0d", nm, k), 32'(got[k]), 32'(exp[k]));
      check({nm, " o_Read low run"}, 32'(max_low), 32'd33);
    end

    // Backpressure: queue fills, COMPARE stalls, then release drains everything in order
    do_reset();
    tbl_fill(0, 0);
    i_IDPair_Read = 1'b0;
    for (int f = 0; f < 33; f++) push_fp(mk_fp(0, f));
    wait_drain("bp");
    tick(80);
    check("bp ready", 32'(o_IDPair_Ready), 32'd1);
    check("bp head", 32'(o_IDPair_Out), 32'({10'd0, 10'd32}));
    check("bp stalled o_Read", 32'(o_Read), 32'd0);
    check("bp no pops", 32'(got.size()), 32'd0);
    i_IDPair_Read = 1'b1;
    tick(80);
    check("bp count", 32'(got.size()), 32'd32);
    for (int k = 0; k < got.size() && k < 32; k++)
      check($sformatf("bp pair%0d", k), 32'(got[k]), 32'({10'(k), 10'd32}));
    check("bp ready after", 32'(o_IDPair_Ready), 32'd0);

    // Reset during COMPARE, then IDs restart at 0 and refs reload
    do_reset();
    i_IDPair_Read = 1'b1;
    for (int f = 0; f < 33; f++) push_fp(mk_fp(0, f));
    t = 0;
    while (got.size() == 0 && t < 3000) begin
      tick(1);
      t++;
    end
    check("mid first pair seen", 32'(t < 3000), 32'd1);
    rstn = 1'b0;
    wq.delete();
    tick(1);
    check("mid rst o_Read", 32'(o_Read), 32'd0);
    check("mid rst ready", 32'(o_IDPair_Ready), 32'd0);
    check("mid rst out", 32'(o_IDPair_Out), 32'd0);
    rstn = 1'b1;
    got.delete();
    for (int f = 0; f < 33; f++) push_fp(mk_fp(0, f));
    wait_drain("mid");
    tick(60);
    check("mid count", 32'(got.size()), 32'd32);
    if (got.size() == 32) begin
      check("mid first", 32'(got[0]), 32'({10'd0, 10'd32}));
      check("mid last", 32'(got[31]), 32'({10'd31, 10'd32}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
